// File: rtl/vram_pkg.sv
// Shared text-VRAM constants, requester indices and arbiter state encoding.
package vram_pkg;
  localparam int VRAM_AW    = 11;
  localparam int VRAM_DW    = 8;
  localparam int REQ_CTRL   = 0;
  localparam int REQ_SCROLL = 1;
  localparam int REQ_CLEAR  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } arb_state_e;
endpackage

// File: rtl/arb_pick.sv
// Combinational winner picker: fixed priority (lowest index) by default,
// round-robin after the last owner when VRAM_ARB_ROUND_ROBIN_EN is defined.
module arb_pick import vram_pkg::*; #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            ptr_vld,
  input  logic [NREQ-1:0] excl,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_idx
);
  logic [NREQ-1:0] cand;

  // The exclude mask only applies when someone else is actually waiting.
  assign cand = ((req & ~excl) != '0) ? (req & ~excl) : req;

`ifdef VRAM_ARB_ROUND_ROBIN_EN
  // Reverse scan so the first hit in scan order (start, start+1, ...) wins.
  always_comb begin
    int start;
    int j;
    win     = '0;
    win_idx = '0;
    start   = ptr_vld ? int'(ptr) + 1 : 0;
    j       = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = start + i;
      if (j >= NREQ) j = j - NREQ;
      if (cand[IW'(j)]) begin
        win            = '0;
        win[IW'(j)]    = 1'b1;
        win_idx        = IW'(j);
      end
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{ptr, ptr_vld};

  always_comb begin
    win     = '0;
    win_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win     = '0;
        win[i]  = 1'b1;
        win_idx = IW'(i);
      end
    end
  end
`endif
endmodule

// File: rtl/vram_arbiter.sv
// Text-VRAM arbiter: registered one-hot grant, burst locking, MAX_BURST fairness turn.
// Arbitration policy selected by VRAM_ARB_ROUND_ROBIN_EN (undefined = fixed priority).
module vram_arbiter import vram_pkg::*; #(
  parameter int NREQ      = 3,
  parameter int AW        = VRAM_AW,
  parameter int DW        = VRAM_DW,
  parameter int MAX_BURST = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ-1:0]    i_wre,
  input  logic [NREQ*AW-1:0] i_addr,
  input  logic [NREQ*DW-1:0] i_din,
  output logic [NREQ-1:0]    o_gnt,
  output logic [DW-1:0]      o_rdata,
  output logic [NREQ-1:0]    o_rvalid,
  output logic [AW-1:0]      o_vram_addr,
  output logic [DW-1:0]      o_vram_din,
  output logic               o_vram_ce,
  output logic               o_vram_wre,
  input  logic [DW-1:0]      i_vram_dout
);
  localparam int IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW        = $clog2(MAX_BURST + 1);
  localparam int RD_STAGES = 1;
  localparam logic [CW-1:0] BURST_LIM = CW'(MAX_BURST);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_d, last_q, last_d, excl, win, acc, rd_acc;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [IW-1:0]   ptr_q, ptr_d, win_idx;
  logic            ptr_vld_q, ptr_vld_d, others;
  logic [RD_STAGES-1:0][NREQ-1:0] tag_pipe;

  // Only cycles with both grant and request are real VRAM accesses.
  assign acc         = o_gnt & i_req;
  assign rd_acc      = acc & ~i_wre;
  assign o_vram_ce   = |acc;
  assign o_vram_wre  = |(acc & i_wre);
  assign o_rdata     = i_vram_dout;
  assign o_rvalid    = tag_pipe[RD_STAGES-1];
  assign others      = |(i_req & ~o_gnt);
  assign excl        = (state_q == ST_TURN) ? last_q : '0;
  assign cnt_inc     = (cnt_q == BURST_LIM) ? cnt_q : cnt_q + CW'(1);

  // AND-OR mux on the one-hot grant; no owner drives zeros.
  always_comb begin
    o_vram_addr = '0;
    o_vram_din  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (o_gnt[k]) begin
        o_vram_addr = o_vram_addr | i_addr[k*AW +: AW];
        o_vram_din  = o_vram_din  | i_din[k*DW +: DW];
      end
    end
  end

  arb_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req     (i_req),
    .ptr     (ptr_q),
    .ptr_vld (ptr_vld_q),
    .excl    (excl),
    .win     (win),
    .win_idx (win_idx)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = o_gnt;
    cnt_d     = cnt_q;
    last_d    = last_q;
    ptr_d     = ptr_q;
    ptr_vld_d = ptr_vld_q;
    case (state_q)
      ST_IDLE, ST_TURN: begin
        if (|i_req) begin
          gnt_d     = win;
          last_d    = win;
          ptr_d     = win_idx;
          ptr_vld_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_OWN;
        end else begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_OWN: begin
        // A dropped request wins over a simultaneous burst-limit hit.
        if (!(|acc)) begin
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_inc == BURST_LIM) begin
          cnt_d = '0;
          if (others) begin
            gnt_d   = '0;
            state_d = ST_TURN;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        gnt_d   = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      o_gnt     <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
      ptr_q     <= '0;
      ptr_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      o_gnt     <= gnt_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      ptr_q     <= ptr_d;
      ptr_vld_q <= ptr_vld_d;
    end
  end

  // Read tag travels with the VRAM read latency; reset drops in-flight tags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= rd_acc;
      for (int i = 1; i < RD_STAGES; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: queued expected reads and ownerships, checked by a monitor.
module tb_vram_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 11;
  localparam int DW   = 8;

  typedef struct { logic [2:0] tag; logic [7:0] data; } rd_t;
  typedef struct { logic [2:0] gnt; int n; int gap; } own_t;

  logic              clk, rst;
  logic [NREQ-1:0]   req, wre;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] din;
  logic [NREQ-1:0]   gnt, rvalid;
  logic [DW-1:0]     rdata, vram_din, vram_dout;
  logic [AW-1:0]     vram_addr;
  logic              vram_ce, vram_wre;

  int checks = 0;
  int failures = 0;
  rd_t  exp_rd[$];
  own_t exp_own[$];

  vram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_wre(wre), .i_addr(addr), .i_din(din),
    .o_gnt(gnt), .o_rdata(rdata), .o_rvalid(rvalid), .o_vram_addr(vram_addr),
    .o_vram_din(vram_din), .o_vram_ce(vram_ce), .o_vram_wre(vram_wre),
    .i_vram_dout(vram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM model: unwritten cells hold a fixed pattern, 041 holds 5A.
  function automatic logic [7:0] pat(input logic [10:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return (a == 11'h041) ? 8'h5A : (lo ^ 8'hA5);
  endfunction

  logic [7:0]    wr_mem [0:2047];
  logic [2047:0] wr_vld;
  always @(posedge clk) begin
    if (rst) wr_vld <= '0;
    else if (vram_ce) begin
      if (vram_wre) begin
        wr_mem[vram_addr] <= vram_din;
        wr_vld[vram_addr] <= 1'b1;
      end else begin
        vram_dout <= wr_vld[vram_addr] ? wr_mem[vram_addr] : pat(vram_addr);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic r, input logic w,
                         input logic [10:0] a, input logic [7:0] d);
    req[k] = r;
    wre[k] = w;
    addr[k*AW +: AW] = a;
    din[k*DW +: DW] = d;
  endtask

  task automatic wait_gnt(input logic [2:0] m, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (gnt !== m && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_gnt", 32'(gnt), 32'(m));
  endtask

  task automatic push_own(input logic [2:0] g, input int n, input int gap);
    own_t o;
    o.gnt = g; o.n = n; o.gap = gap;
    exp_own.push_back(o);
  endtask

  task automatic push_rd(input logic [2:0] t, input logic [7:0] d);
    rd_t r;
    r.tag = t; r.data = d;
    exp_rd.push_back(r);
  endtask

  // Monitor: read responses and completed ownerships (grant, access count, idle gap before).
  logic [2:0] cur_gnt;
  int zero_cnt, n_ce, gap;

  task automatic end_own();
    own_t o;
    if (exp_own.size() == 0) begin
      chk("own_unexpected", 32'(cur_gnt), 32'(0));
    end else begin
      o = exp_own.pop_front();
      chk("own_gnt", 32'(cur_gnt), 32'(o.gnt));
      chk("own_accesses", 32'(n_ce), 32'(o.n));
      if (o.gap != 255) chk("own_gap", 32'(gap), 32'(o.gap));
    end
    cur_gnt = '0;
  endtask

  initial begin
    cur_gnt = '0; zero_cnt = 0; n_ce = 0; gap = 0;
  end

  always @(negedge clk) begin
    rd_t r;
    if (rst) begin
      cur_gnt  = '0;
      zero_cnt = 0;
    end else begin
      if (|rvalid) begin
        if (exp_rd.size() == 0) chk("rvalid_unexpected", {21'd0, rvalid, rdata}, 32'd0);
        else begin
          r = exp_rd.pop_front();
          chk("rvalid_data", {21'd0, rvalid, rdata}, {21'd0, r.tag, r.data});
        end
      end
      if (cur_gnt != 0 && gnt != cur_gnt) end_own();
      if (gnt != 0) begin
        if (cur_gnt == 0) begin
          cur_gnt = gnt;
          n_ce    = 0;
          gap     = zero_cnt;
        end
        if (vram_ce) n_ce++;
        zero_cnt = 0;
      end else begin
        zero_cnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; wre = '0; addr = '0; din = '0;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_ce", 32'(vram_ce), 32'd0);
    chk("rst_wre", 32'(vram_wre), 32'd0);
    chk("rst_addr", 32'(vram_addr), 32'd0);
    chk("rst_din", 32'(vram_din), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    tick(2);

    // Single read by requester 1
    push_own(3'b010, 1, 255);
    push_rd(3'b010, 8'h5A);
    set_req(1, 1'b1, 1'b0, 11'h041, 8'h00);
    @(negedge clk);
    chk("read_latency_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    chk("read_gnt", 32'(gnt), 32'b010);
    chk("read_ce", 32'(vram_ce), 32'd1);
    chk("read_addr", 32'(vram_addr), 32'h041);
    chk("read_wre", 32'(vram_wre), 32'd0);
    tick(1);
    set_req(1, 1'b0, 1'b0, 11'h0, 8'h00);
    tick(3);

    // Lone owner keeps the grant through repeated burst-limit hits
    push_own(3'b100, 39, 255);
    set_req(2, 1'b1, 1'b1, 11'h3FF, 8'h05);
    wait_gnt(3'b100, 4);
    tick(39);
    set_req(2, 1'b0, 1'b0, 11'h0, 8'h00);
    tick(3);

    // Priority: 0 and 2 together; 0 writes three cells, 2 reads them back after one bubble
    push_own(3'b001, 3, 255);
    push_own(3'b100, 2, 1);
    push_rd(3'b100, 8'h22);
    push_rd(3'b100, 8'h33);
    set_req(0, 1'b1, 1'b1, 11'h100, 8'h11);
    set_req(2, 1'b1, 1'b0, 11'h101, 8'h00);
    wait_gnt(3'b001, 4);
    tick(1); set_req(0, 1'b1, 1'b1, 11'h101, 8'h22);
    tick(1); set_req(0, 1'b1, 1'b1, 11'h102, 8'h33);
    tick(1); set_req(0, 1'b0, 1'b0, 11'h0, 8'h00);
    wait_gnt(3'b100, 6);
    tick(1); set_req(2, 1'b1, 1'b0, 11'h102, 8'h00);
    tick(1); set_req(2, 1'b0, 1'b0, 11'h0, 8'h00);
    tick(3);

    // All three held: burst-limit turns rotate ownership
`ifdef VRAM_ARB_ROUND_ROBIN_EN
    push_own(3'b001, 4, 255);
    push_own(3'b010, 4, 1);
    push_own(3'b100, 4, 1);
    push_own(3'b001, 2, 1);
`else
    push_own(3'b001, 4, 255);
    push_own(3'b010, 4, 1);
    push_own(3'b001, 4, 1);
    push_own(3'b010, 2, 1);
`endif
    set_req(0, 1'b1, 1'b1, 11'h010, 8'hA0);
    set_req(1, 1'b1, 1'b1, 11'h020, 8'hB0);
    set_req(2, 1'b1, 1'b1, 11'h030, 8'hC0);
    wait_gnt(3'b001, 4);
    tick(17);
    req = '0; wre = '0;
    tick(3);

    // Burst limit: 1 reading, 2 arrives -> 4 accesses, TURN, 2, then 1 resumes
    push_own(3'b010, 4, 255);
    push_own(3'b100, 1, 1);
    push_own(3'b010, 2, 1);
    repeat (6) push_rd(3'b010, 8'hA5);
    set_req(1, 1'b1, 1'b0, 11'h200, 8'h00);
    wait_gnt(3'b010, 4);
    tick(1); set_req(2, 1'b1, 1'b1, 11'h300, 8'h77);
    wait_gnt(3'b100, 10);
    tick(1); set_req(2, 1'b0, 1'b0, 11'h0, 8'h00);
    wait_gnt(3'b010, 10);
    tick(1);
    tick(1); set_req(1, 1'b0, 1'b0, 11'h0, 8'h00);
    tick(3);

    // Reset during a granted read: grant and pending rvalid vanish at once
    set_req(1, 1'b1, 1'b0, 11'h041, 8'h00);
    wait_gnt(3'b010, 4);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_gnt", 32'(gnt), 32'd0);
    chk("rstmid_rvalid", 32'(rvalid), 32'd0);
    chk("rstmid_ce", 32'(vram_ce), 32'd0);
    req = '0;
    @(negedge clk);
    chk("rstmid_rvalid_hold", 32'(rvalid), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_rvalid", 32'(rvalid), 32'd0);
      chk("post_rst_gnt", 32'(gnt), 32'd0);
    end
    tick(2);

    chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    chk("own_queue_empty", 32'(exp_own.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
